// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, CLEANUP, BREAK
  } uart_rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } uart_tx_state_t;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus from the UART receiver to its consumer (command parser).
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      frame_err;
  logic                      active;

  modport master (output data, valid, frame_err, active);
  modport slave  (input  data, valid, frame_err, active);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; RST_VAL selects the value both flops take while in reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, samples each bit at its centre, strobes good bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rxd,
  uart_rx_if.master rx
);

  localparam int             CW       = cnt_width(CLKS_PER_BIT);
  localparam int             HALF     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0]  HALF_C   = CW'(HALF);
  localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rst_int_n;
  logic                      rxd_s;
  uart_rx_state_t            state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      frame_err_q;
  logic                      active_q;

  // Reset asserts immediately but releases on a clock edge.
  uart_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  // Line idles high, so the synchronizer resets high and never fakes a start bit.
  uart_sync2 #(.RST_VAL(1'b1)) u_rxd_sync (
    .clk   (clk),
    .rst_n (rst_int_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          active_q <= 1'b0;
          if (!rxd_s) begin
            state    <= START;
            active_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (!rxd_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state    <= IDLE;
              active_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxd_s;
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rxd_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              state   <= CLEANUP;
            end else begin
              frame_err_q <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEANUP: begin
          state    <= IDLE;
          active_q <= 1'b0;
        end
        BREAK: begin
          // Wait out a held-low line so it reports one error, not one per bit time.
          if (rxd_s) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.active    = active_q;

endmodule
